// File: rtl/module_mem_access_unit_if.sv
// Bus side of the memory access unit: request/acknowledge handshake with
// address, write data and write enable held stable while a request is open.
interface module_mem_access_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              bus_req_o;
    logic              bus_we_o;
    logic [ADDR_W-1:0] bus_adr_o;
    logic [DATA_W-1:0] bus_wd_o;
    logic [DATA_W-1:0] bus_rd_i;
    logic              bus_ack_i;

    // The access unit drives the request side.
    modport master (
        output bus_req_o,
        output bus_we_o,
        output bus_adr_o,
        output bus_wd_o,
        input  bus_rd_i,
        input  bus_ack_i
    );

    // The memory/peripheral answers.
    modport slave (
        input  bus_req_o,
        input  bus_we_o,
        input  bus_adr_o,
        input  bus_wd_o,
        output bus_rd_i,
        output bus_ack_i
    );
endinterface

// File: rtl/module_mem_access_unit.sv
// Memory access unit between the multicycle core and the external bus.
// Registers each access, runs a req/ack handshake guarded by a watchdog,
// captures read data and stalls the controller until the access completes.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no access in flight, waiting for req_i
// WAIT  | bus_req_o high, counting cycles until ack or watchdog expiry
// DONE  | one-cycle completion (done_o), may accept the next request
// ERR   | one-cycle error: misaligned or unanswered access, sets err_o
module module_mem_access_unit #(
    parameter int                 ADDR_W   = 32,
    parameter int                 DATA_W   = 32,
    parameter int                 TIMEOUT  = 16,
    parameter logic [DATA_W-1:0]  ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     adr_i,
    input  logic [DATA_W-1:0]     wd_i,
    input  logic                  err_clr_i,
    output logic                  stall_o,
    output logic                  done_o,
    output logic [DATA_W-1:0]     data_o,
    output logic                  err_o,
    module_mem_access_unit_if.master bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                acc_we_q, acc_we_d;
    logic                bus_req_q, bus_req_d;
    logic                bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]   bus_adr_q, bus_adr_d;
    logic [DATA_W-1:0]   bus_wd_q, bus_wd_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                err_q, err_d;
    logic                err_set;
    logic                stall;
    logic                done;

    // State and access registers; synchronous reset abandons any open access.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_we_q  <= 1'b0;
            bus_req_q <= 1'b0;
            bus_we_q  <= 1'b0;
            bus_adr_q <= '0;
            bus_wd_q  <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_we_q  <= acc_we_d;
            bus_req_q <= bus_req_d;
            bus_we_q  <= bus_we_d;
            bus_adr_q <= bus_adr_d;
            bus_wd_q  <= bus_wd_d;
            data_q    <= data_d;
            err_q     <= err_d;
        end
    end

    // Next-state, datapath updates and combinational stall/done.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_we_d  = acc_we_q;
        bus_req_d = bus_req_q;
        bus_we_d  = bus_we_q;
        bus_adr_d = bus_adr_q;
        bus_wd_d  = bus_wd_q;
        data_d    = data_q;
        err_set   = 1'b0;
        stall     = 1'b0;
        done      = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                done = (state_q == ST_DONE);
                if (req_i) begin
                    stall    = 1'b1;
                    // Kept separately from bus_we_o so a misaligned access
                    // still knows whether to load ERR_DATA.
                    acc_we_d = we_i;
                    if (adr_i[1:0] == 2'b00) begin
                        bus_adr_d = adr_i;
                        bus_wd_d  = wd_i;
                        bus_we_d  = we_i;
                        bus_req_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = ST_WAIT;
                    end else begin
                        state_d = ST_ERR;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                stall = 1'b1;
                if (bus.bus_ack_i) begin
                    bus_req_d = 1'b0;
                    if (!acc_we_q) begin
                        data_d = bus.bus_rd_i;
                    end
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    bus_req_d = 1'b0;
                    state_d   = ST_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ERR: begin
                stall   = 1'b1;
                err_set = 1'b1;
                if (!acc_we_q) begin
                    data_d = ERR_DATA;
                end
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new error outranks a clear in the same cycle.
        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    assign stall_o       = stall;
    assign done_o        = done;
    assign data_o        = data_q;
    assign err_o         = err_q;
    assign bus.bus_req_o = bus_req_q;
    assign bus.bus_we_o  = bus_we_q;
    assign bus.bus_adr_o = bus_adr_q;
    assign bus.bus_wd_o  = bus_wd_q;

endmodule

// File: tb/tb_module_mem_access_unit.sv
// Directed bench for the memory access unit: reads, writes, watchdog
// timeout, misaligned access, back-to-back accesses and mid-access reset.
module tb_module_mem_access_unit;

    logic        clk_i;
    logic        rst_i;
    logic        req_i;
    logic        we_i;
    logic [31:0] adr_i;
    logic [31:0] wd_i;
    logic        err_clr_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] data_o;
    logic        err_o;

    int n_checks = 0;
    int n_pass   = 0;
    int stall_cnt;
    int req_cycles;

    module_mem_access_unit_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

    module_mem_access_unit #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT(16), .ERR_DATA(32'hDEAD_BEEF)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .we_i      (we_i),
        .adr_i     (adr_i),
        .wd_i      (wd_i),
        .err_clr_i (err_clr_i),
        .stall_o   (stall_o),
        .done_o    (done_o),
        .data_o    (data_o),
        .err_o     (err_o),
        .bus       (bus_if)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    initial begin
        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; adr_i = '0; wd_i = '0;
        err_clr_i = 1'b0;
        bus_if.bus_ack_i = 1'b0; bus_if.bus_rd_i = '0;
        tick(); tick();
        rst_i = 1'b0; settle();
        check("rst_stall", stall_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        check("rst_bus_req", bus_if.bus_req_o, 0);
        check("rst_bus_we", bus_if.bus_we_o, 0);
        check("rst_data", data_o, 0);
        check("rst_bus_adr", bus_if.bus_adr_o, 0);
        check("rst_bus_wd", bus_if.bus_wd_o, 0);
        tick();

        // Read 0x100, ack in the third WAIT cycle.
        stall_cnt = 0;
        req_i = 1; we_i = 0; adr_i = 32'h100; settle();
        stall_cnt += int'(stall_o);
        tick();
        req_i = 0; settle();
        check("t1_bus_req", bus_if.bus_req_o, 1);
        check("t1_bus_adr", bus_if.bus_adr_o, 32'h100);
        check("t1_bus_we", bus_if.bus_we_o, 0);
        stall_cnt += int'(stall_o);
        tick(); settle();
        check("t1_no_done_early", done_o, 0);
        stall_cnt += int'(stall_o);
        tick();
        bus_if.bus_ack_i = 1; bus_if.bus_rd_i = 32'h1234_5678; settle();
        stall_cnt += int'(stall_o);
        tick();
        bus_if.bus_ack_i = 0; bus_if.bus_rd_i = '0; settle();
        check("t1_done", done_o, 1);
        check("t1_data", data_o, 32'h1234_5678);
        check("t1_stall_low", stall_o, 0);
        check("t1_err", err_o, 0);
        check("t1_bus_req_drop", bus_if.bus_req_o, 0);
        stall_cnt += int'(stall_o);
        tick(); settle();
        check("t1_done_one_pulse", done_o, 0);
        check("t1_stall_cycles", stall_cnt, 4);

        // Write 0x200, ack in the first WAIT cycle.
        req_i = 1; we_i = 1; adr_i = 32'h200; wd_i = 32'hCAFE_F00D; settle();
        tick();
        req_i = 0; we_i = 0; wd_i = 32'h0; adr_i = 32'h0;
        bus_if.bus_ack_i = 1; bus_if.bus_rd_i = 32'h5555_AAAA; settle();
        check("t2_bus_we", bus_if.bus_we_o, 1);
        check("t2_bus_wd", bus_if.bus_wd_o, 32'hCAFE_F00D);
        check("t2_bus_adr", bus_if.bus_adr_o, 32'h200);
        tick();
        bus_if.bus_ack_i = 0; settle();
        check("t2_done", done_o, 1);
        check("t2_data_kept", data_o, 32'h1234_5678);
        check("t2_bus_wd_hold", bus_if.bus_wd_o, 32'hCAFE_F00D);
        tick();

        // Read 0x300 with no ack: watchdog after 16 WAIT cycles.
        req_i = 1; we_i = 0; adr_i = 32'h300; settle();
        tick();
        req_i = 0; settle();
        req_cycles = 0;
        while (bus_if.bus_req_o && req_cycles < 40) begin
            req_cycles++;
            tick();
        end
        check("t3_req_cycles", req_cycles, 16);
        check("t3_err_state_stall", stall_o, 1);
        check("t3_err_state_no_done", done_o, 0);
        tick();
        check("t3_done", done_o, 1);
        check("t3_err", err_o, 1);
        check("t3_data", data_o, 32'hDEAD_BEEF);
        err_clr_i = 1;
        tick();
        err_clr_i = 0; settle();
        check("t3_err_clr", err_o, 0);

        // Misaligned write 0x103; clear asserted during ERR loses to set.
        req_i = 1; we_i = 1; adr_i = 32'h103; wd_i = 32'h1111_2222; settle();
        check("t4_stall", stall_o, 1);
        tick();
        req_i = 0; we_i = 0; err_clr_i = 1; settle();
        check("t4_no_bus_req", bus_if.bus_req_o, 0);
        check("t4_no_done_c1", done_o, 0);
        tick();
        err_clr_i = 0; settle();
        check("t4_done_c2", done_o, 1);
        check("t4_err_set_wins", err_o, 1);
        check("t4_bus_req_still_low", bus_if.bus_req_o, 0);
        check("t4_data_write_kept", data_o, 32'hDEAD_BEEF);
        err_clr_i = 1;
        tick();
        err_clr_i = 0; settle();
        check("t4_err_clr", err_o, 0);

        // Back-to-back reads, second request held into DONE.
        req_i = 1; we_i = 0; adr_i = 32'h400; settle();
        tick();
        adr_i = 32'h404;
        bus_if.bus_ack_i = 1; bus_if.bus_rd_i = 32'hAAAA_0001; settle();
        tick();
        bus_if.bus_ack_i = 0; settle();
        check("t5_done1", done_o, 1);
        check("t5_data1", data_o, 32'hAAAA_0001);
        check("t5_stall_in_done", stall_o, 1);
        check("t5_req_low_in_done", bus_if.bus_req_o, 0);
        tick();
        req_i = 0;
        bus_if.bus_ack_i = 1; bus_if.bus_rd_i = 32'hBBBB_0002; settle();
        check("t5_bus_req2", bus_if.bus_req_o, 1);
        check("t5_bus_adr2", bus_if.bus_adr_o, 32'h404);
        check("t5_data_hold", data_o, 32'hAAAA_0001);
        tick();
        bus_if.bus_ack_i = 0; settle();
        check("t5_done2", done_o, 1);
        check("t5_data2", data_o, 32'hBBBB_0002);
        tick();

        // Reset in WAIT cycle 2, then a late ack.
        req_i = 1; we_i = 0; adr_i = 32'h500; settle();
        tick();
        req_i = 0; settle();
        tick();
        rst_i = 1; settle();
        check("t6_req_before_rst", bus_if.bus_req_o, 1);
        tick();
        rst_i = 0;
        bus_if.bus_ack_i = 1; bus_if.bus_rd_i = 32'hFFFF_0000; settle();
        check("t6_bus_req", bus_if.bus_req_o, 0);
        check("t6_stall", stall_o, 0);
        check("t6_done", done_o, 0);
        check("t6_data_rst", data_o, 0);
        tick();
        bus_if.bus_ack_i = 0; settle();
        check("t6_late_ack_done", done_o, 0);
        check("t6_late_ack_data", data_o, 0);
        check("t6_late_ack_req", bus_if.bus_req_o, 0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
